// File: rtl/mu0_mem_resp_if.sv
// MU0 memory bus: CPU-side request (Req/Wr/Addr/WData) and memory-side response (Ack/RData/Busy).
interface mu0_mem_resp_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          Req;
  logic          Wr;
  logic [AW-1:0] Addr;
  logic [DW-1:0] WData;
  logic          Ack;
  logic [DW-1:0] RData;
  logic          Busy;

  modport master (output Req, Wr, Addr, WData, input Ack, RData, Busy);
  modport slave  (input Req, Wr, Addr, WData, output Ack, RData, Busy);
endinterface

// File: rtl/mu0_mem_resp.sv
// MU0 memory responder: 2^AW x DW store, Ack pulse WAIT_STATES+1 cycles after Req capture.
// Requests are ignored while Busy; the CPU holds Req until it sees the one-cycle Ack.
module mu0_mem_resp #(
  parameter int WAIT_STATES = 2,
  parameter int AW          = 12,
  parameter int DW          = 16
) (
  input logic          Clk,
  input logic          Reset_n,
  mu0_mem_resp_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t        state;
  logic [3:0]    cnt;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] mem [2**AW];

  logic          acc_en;
  logic          acc_wr;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  // With no wait states the access happens on the capture edge itself, so it uses the live inputs.
  always_comb begin
    acc_en    = 1'b0;
    acc_wr    = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state == IDLE) begin
      acc_wr    = bus.Wr;
      acc_addr  = bus.Addr;
      acc_wdata = bus.WData;
      acc_en    = bus.Req && (WS == 4'd0) && Reset_n;
    end else if (state == WAIT) begin
      acc_en    = (cnt == 4'd1) && Reset_n;
    end
  end

  always_ff @(posedge Clk) begin
    if (acc_en && acc_wr) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (acc_en) begin
        rdata_q <= acc_wr ? acc_wdata : mem[acc_addr];
      end
      case (state)
        IDLE: begin
          if (bus.Req) begin
            wr_q    <= bus.Wr;
            addr_q  <= bus.Addr;
            wdata_q <= bus.WData;
            cnt     <= WS;
            state   <= (WS == 4'd0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Ack   = (state == ACK);
  assign bus.Busy  = (state != IDLE);
  assign bus.RData = rdata_q;
endmodule
